// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE-ALL, N auto-refreshes, MRS.
// Define SDRAM_INIT_EMRS_EN to add an EMRS step (EMRS_VALUE, bank 2'b10) after the MRS.
//
// state      | meaning
// WAIT_PU    | CKE raised, counting the power-up time
// PRE        | PRECHARGE-ALL on the bus
// WAIT_RP    | precharge recovery
// AREF       | AUTO-REFRESH on the bus
// WAIT_RFC   | refresh recovery, then another AREF or the MRS
// MRS        | MODE REGISTER SET on the bus
// WAIT_MRD   | mode register recovery
// EMRS       | EXTENDED MODE REGISTER SET on the bus (optional)
// WAIT_EMRD  | extended mode register recovery (optional)
// DONE       | idle at NOP, bus handed to the arbiter
module sdram_init_ctrl #(
    parameter int         T_POWERUP   = 10000,
    parameter int         T_RP        = 2,
    parameter int         T_RFC       = 7,
    parameter int         T_MRD       = 2,
    parameter int         N_AREF      = 2,
    parameter int         ADDR_W      = 12,
    parameter int         BA_W        = 2,
    parameter int         CAS_LAT     = 3,
    parameter logic [2:0] BURST_LEN   = 3'b010,
    parameter int         BURST_TYPE  = 0,
    parameter int         WRITE_BURST = 0
`ifdef SDRAM_INIT_EMRS_EN
    ,
    parameter logic [ADDR_W-1:0] EMRS_VALUE = '0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              sdram_cke,
    output logic [3:0]        cmd_reg,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic              init_busy,
    output logic              init_done
);

    typedef enum logic [3:0] {
        S_WAIT_PU, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_MRS, S_WAIT_MRD,
`ifdef SDRAM_INIT_EMRS_EN
        S_EMRS, S_WAIT_EMRD,
`endif
        S_DONE
    } state_t;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam int MAX_A = (T_POWERUP > T_RFC) ? T_POWERUP : T_RFC;
    localparam int MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T + 1);

    // Power-up load is the full count because it starts on the same edge CKE rises.
    localparam logic [CW-1:0] PU_LD  = CW'(T_POWERUP);
    localparam logic [CW-1:0] RP_LD  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RFC_LD = CW'(T_RFC - 1);
    localparam logic [CW-1:0] MRD_LD = CW'(T_MRD - 1);

    localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(11'h400);
    localparam logic [ADDR_W-1:0] MRS_WORD  = ADDR_W'({1'(WRITE_BURST), 2'b00, 3'(CAS_LAT),
                                                       1'(BURST_TYPE), BURST_LEN});

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [3:0]        ref_cnt, ref_nxt;
    logic [3:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic              done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_WAIT_PU;
            cnt        <= PU_LD;
            ref_cnt    <= '0;
            sdram_cke  <= 1'b0;
            cmd_reg    <= CMD_NOP;
            sdram_addr <= '0;
            sdram_ba   <= '0;
            init_busy  <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ref_cnt    <= ref_nxt;
            sdram_cke  <= 1'b1;
            cmd_reg    <= cmd_nxt;
            sdram_addr <= addr_nxt;
            sdram_ba   <= ba_nxt;
            init_busy  <= ~done_nxt;
            init_done  <= done_nxt;
        end
    end

    // Command and wait states share the gap logic: leave when the counter hits zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CW'(1);
        ref_nxt   = ref_cnt;
        unique case (state)
            S_WAIT_PU: begin
                if (cnt == '0) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = RP_LD;
                    ref_nxt   = '0;
                end
            end
            S_PRE, S_WAIT_RP: begin
                state_nxt = S_WAIT_RP;
                if (cnt == '0) begin
                    state_nxt = S_AREF;
                    cnt_nxt   = RFC_LD;
                    ref_nxt   = ref_cnt + 4'd1;
                end
            end
            S_AREF, S_WAIT_RFC: begin
                state_nxt = S_WAIT_RFC;
                if (cnt == '0) begin
                    if (ref_cnt < 4'(N_AREF)) begin
                        state_nxt = S_AREF;
                        cnt_nxt   = RFC_LD;
                        ref_nxt   = ref_cnt + 4'd1;
                    end else begin
                        state_nxt = S_MRS;
                        cnt_nxt   = MRD_LD;
                    end
                end
            end
            S_MRS, S_WAIT_MRD: begin
                state_nxt = S_WAIT_MRD;
                if (cnt == '0) begin
`ifdef SDRAM_INIT_EMRS_EN
                    state_nxt = S_EMRS;
                    cnt_nxt   = MRD_LD;
`else
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
`endif
                end
            end
`ifdef SDRAM_INIT_EMRS_EN
            S_EMRS, S_WAIT_EMRD: begin
                state_nxt = S_WAIT_EMRD;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
`endif
            S_DONE: begin
                cnt_nxt = cnt;
                if (init_req) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = RP_LD;
                    ref_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_WAIT_PU;
                cnt_nxt   = PU_LD;
            end
        endcase
    end

    always_comb begin
        cmd_nxt  = CMD_NOP;
        addr_nxt = ADDR_IDLE;
        ba_nxt   = '0;
        done_nxt = (state_nxt == S_DONE);
        case (state_nxt)
            S_PRE:  cmd_nxt = CMD_PRE;
            S_AREF: cmd_nxt = CMD_AREF;
            S_MRS: begin
                cmd_nxt  = CMD_MRS;
                addr_nxt = MRS_WORD;
            end
`ifdef SDRAM_INIT_EMRS_EN
            S_EMRS: begin
                cmd_nxt  = CMD_MRS;
                addr_nxt = EMRS_VALUE;
                ba_nxt   = BA_W'(2);
            end
`endif
            default: ;
        endcase
    end

endmodule
